// File: rtl/mem_arb_pkg.sv
// Shared FSM encoding, operation constants and datapath width for the memory issue arbiter.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_MEM  = 3'd2,
        BROADCAST = 3'd3,
        ACK       = 3'd4
    } arbState_t;

    localparam logic OP_LOAD  = 1'b1;
    localparam logic OP_STORE = 1'b0;

    localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/mem_issue_arbiter_rr_pick.sv
// Rotating-priority winner select: first requester at or after ptr, as one-hot and index.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grantOh_c,
    output logic [$clog2(NUM_REQ)-1:0] grantIdx_c,
    output logic                       anyReq_c
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] pos;

    always_comb begin
        grantOh_c  = '0;
        grantIdx_c = '0;
        anyReq_c   = 1'b0;
        pos        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!anyReq_c && req[pos]) begin
                anyReq_c       = 1'b1;
                grantOh_c[pos] = 1'b1;
                grantIdx_c     = pos;
            end
        end
    end

endmodule

// File: rtl/mem_issue_arbiter.sv
// Issues one load/store buffer entry at a time to the memory unit and broadcasts load results on the CDB.
// Define MEM_ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest-index requester always wins.
module mem_issue_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_op,
    input  logic [NUM_REQ*DATA_W-1:0]   req_base,
    input  logic [NUM_REQ*DATA_W-1:0]   req_offset,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*TAG_W-1:0]    req_label,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        mem_WEN,
    output logic [DATA_W-1:0]           mem_dataIn1,
    output logic [DATA_W-1:0]           mem_dataIn2,
    output logic [DATA_W-1:0]           mem_writeData,
    output logic                        mem_op,
    output logic [TAG_W-1:0]            mem_labelIn,
    input  logic                        mem_available,
    input  logic                        mem_require,
    input  logic [DATA_W-1:0]           mem_loadData,
    output logic                        mem_requireAC,
    output logic                        cdb_req,
    input  logic                        cdb_ack,
    output logic [TAG_W-1:0]            cdb_label,
    output logic [DATA_W-1:0]           cdb_data,
    output logic                        busy
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arbState_t          state;
    logic               minWaitDone;
    logic [NUM_REQ-1:0] winOh;
    logic [IDX_W-1:0]   winIdx;
    logic               anyReq;
    logic [IDX_W-1:0]   pickPtr;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   ptr;
    assign pickPtr = ptr;
`else
    assign pickPtr = '0;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) uPick (
        .req        (req_valid),
        .ptr        (pickPtr),
        .grantOh_c  (winOh),
        .grantIdx_c (winIdx),
        .anyReq_c   (anyReq)
    );

    // The CDB tag is the tag latched at issue.
    assign cdb_label = mem_labelIn;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            minWaitDone   <= 1'b0;
            grant         <= '0;
            mem_WEN       <= 1'b0;
            mem_dataIn1   <= '0;
            mem_dataIn2   <= '0;
            mem_writeData <= '0;
            mem_op        <= OP_STORE;
            mem_labelIn   <= '0;
            mem_requireAC <= 1'b0;
            cdb_req       <= 1'b0;
            cdb_data      <= '0;
            busy          <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr           <= '0;
`endif
        end else begin
            grant         <= '0;
            mem_WEN       <= 1'b0;
            mem_requireAC <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq && mem_available) begin
                        grant         <= winOh;
                        mem_WEN       <= 1'b1;
                        mem_op        <= req_op[winIdx];
                        mem_dataIn1   <= req_base[DATA_W*winIdx +: DATA_W];
                        mem_dataIn2   <= req_offset[DATA_W*winIdx +: DATA_W];
                        mem_writeData <= req_wdata[DATA_W*winIdx +: DATA_W];
                        mem_labelIn   <= req_label[TAG_W*winIdx +: TAG_W];
                        busy          <= 1'b1;
                        state         <= ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        ptr <= (32'(winIdx) == NUM_REQ - 1) ? '0 : winIdx + 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    minWaitDone <= 1'b0;
                    state       <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    // Stores skip the first wait cycle so mem_available can drop after the start pulse.
                    if (mem_op == OP_LOAD) begin
                        if (mem_require) begin
                            cdb_data <= mem_loadData;
                            cdb_req  <= 1'b1;
                            state    <= BROADCAST;
                        end
                    end else if (minWaitDone && mem_available) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        minWaitDone <= 1'b1;
                    end
                end
                BROADCAST: begin
                    if (cdb_ack) begin
                        cdb_req       <= 1'b0;
                        mem_requireAC <= 1'b1;
                        state         <= ACK;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_issue_arbiter.md
MEM_ISSUE_ARBITER -- requirements
Module: mem_issue_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, sets the number of load/store buffer requesters (2..8).
REQ-002 Parameter TAG_W, default 5, sets the reservation-station tag width.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 req_valid  in  NUM_REQ  per-entry request, held until granted.
REQ-006 req_op  in  NUM_REQ  per-entry operation: 1=load, 0=store.
REQ-007 req_base, req_offset, req_wdata  in  NUM_REQ*32 each  flattened base (Qj value), offset (A) and store data.
REQ-008 req_label  in  NUM_REQ*TAG_W  flattened issuing tag.
REQ-009 grant  out  NUM_REQ  one-hot, one-cycle pulse naming the accepted entry.
REQ-010 mem_WEN  out  1  one-cycle start pulse to the memory unit.
REQ-011 mem_dataIn1, mem_dataIn2, mem_writeData  out  32 each  base, offset and store data to the memory unit.
REQ-012 mem_op  out  1  load/store to the memory unit; mem_labelIn  out  TAG_W  tag to the memory unit.
REQ-013 mem_available  in  1  memory unit idle; mem_require  in  1  load data ready; mem_loadData  in  32.
REQ-014 mem_requireAC  out  1  one-cycle acknowledge of mem_require.
REQ-015 cdb_req  out  1  request to broadcast a load result; cdb_ack  in  1  broadcast granted.
REQ-016 cdb_label  out  TAG_W, cdb_data  out  32  broadcast payload; busy  out  1  arbiter not in IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_MEM, BROADCAST, ACK.
REQ-018 In IDLE, when any req_valid=1 and mem_available=1, the arbiter SHALL select a winner, latch its op/base/offset/wdata/label, pulse grant for that entry and go to ISSUE in the same edge.
REQ-019 In ISSUE, mem_WEN SHALL be 1 for exactly one cycle with latched operands on mem_* outputs; next state WAIT_MEM.
REQ-020 mem_* operand outputs SHALL hold latched values from ISSUE until return to IDLE.
REQ-021 In WAIT_MEM, a store SHALL return to IDLE on the first cycle mem_available=1 at least two cycles after ISSUE.
REQ-022 In WAIT_MEM, a load SHALL capture mem_loadData into cdb_data on mem_require=1 and go to BROADCAST.
REQ-023 In BROADCAST, cdb_req=1 with cdb_label=latched tag; on cdb_ack=1 go to ACK; cdb_req SHALL drop the following cycle.
REQ-024 In ACK, mem_requireAC SHALL be 1 for exactly one cycle; next state IDLE.
REQ-025 Total issue-to-IDLE latency SHALL be memory latency plus 3 cycles for loads (with immediate cdb_ack), plus 2 for stores.
REQ-026 cdb_ack outside BROADCAST and mem_require outside WAIT_MEM SHALL be ignored.
REQ-027 Deassertion of req_valid after grant SHALL not affect the in-flight access.
REQ-028 With no req_valid, or mem_available=0, the FSM SHALL remain in IDLE with grant=0.

Reset
REQ-029 rst=1 SHALL force IDLE, clear grant, mem_WEN, mem_requireAC, cdb_req, busy, all latched operands and cdb_data to 0, and the priority pointer to 0, including mid-access.

Configuration
REQ-030 With MEM_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first valid entry at or after the pointer, and the pointer SHALL become winner+1 modulo NUM_REQ on each grant.
REQ-031 Without MEM_ARB_ROUND_ROBIN_EN, the winner SHALL be the lowest-index valid entry and no pointer register SHALL exist.

Structure
REQ-032 FSM state encoding and the load/store op constants SHALL live in a shared package mem_arb_pkg.
REQ-033 Winner selection SHALL be one sub-module, rr_pick, returning a one-hot grant and its index.

Verification
REQ-034 Single load, entry 2, base 0x100, offset 0x4, tag 5 -> grant=0100, mem_WEN pulse, dataIn1+dataIn2=0x104, cdb_req with label 5 and loaded data, mem_requireAC one pulse.
REQ-035 Single store, entry 0, wdata 0xDEADBEEF -> mem_writeData=0xDEADBEEF, mem_op=0, no cdb_req, busy clears when mem_available returns.
REQ-036 All four entries valid continuously, round-robin enabled -> grant sequence 0,1,2,3,0; disabled -> entry 0 every time.
REQ-037 cdb_ack held low 10 cycles in BROADCAST -> cdb_req held 10 cycles, no new grant, mem_requireAC only after ack.
REQ-038 rst asserted during WAIT_MEM of a load -> next cycle all outputs 0, IDLE; mem_require afterwards produces no cdb_req.
REQ-039 mem_available=0 with req_valid=1 for 5 cycles -> no grant until mem_available=1.
